// File: rtl/iob_eth_pkg.sv
// rtl/iob_eth_pkg.sv - MAC register map, PHY constants and init FSM states
package iob_eth_pkg;

  typedef enum logic [3:0] {
    W_MRST, W_MCLR, W_MIIM, W_MA0, W_MA1, W_MIIA, W_MIIC,
    R_STAT, R_RXD, GAP, W_EN, DONE
  } init_state_e;

  localparam logic [7:0] MODER_OFS      = 8'h00;
  localparam logic [7:0] MIIMODER_OFS   = 8'h28;
  localparam logic [7:0] MIICOMMAND_OFS = 8'h2C;
  localparam logic [7:0] MIIADDRESS_OFS = 8'h30;
  localparam logic [7:0] MIIRX_DATA_OFS = 8'h38;
  localparam logic [7:0] MIISTATUS_OFS  = 8'h3C;
  localparam logic [7:0] MAC_ADDR0_OFS  = 8'h40;
  localparam logic [7:0] MAC_ADDR1_OFS  = 8'h44;

  localparam logic [31:0] MODER_RST     = 32'h0000_0800;
  localparam logic [31:0] MODER_DEFAULT = 32'h0000_A000;
  localparam logic [31:0] MODER_TXEN    = 32'h0000_0002;
  localparam logic [31:0] MODER_RXEN    = 32'h0000_0001;
  localparam logic [31:0] MIICMD_RSTAT  = 32'h0000_0002;

  localparam int MIISTATUS_BUSY = 1;
  localparam int BMSR_LINK      = 2;
  localparam logic [4:0] PHY_BMSR = 5'd1;

endpackage

// File: rtl/iob_eth_init_ctrl.sv
// rtl/iob_eth_init_ctrl.sv - MAC bring-up sequencer and CPU/init arbiter on the IOb port
module iob_eth_init_ctrl
  import iob_eth_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 32,
  parameter logic [47:0] MAC_ADDR  = 48'h0000_0000_0000,
  parameter logic [4:0]  PHY_ADDR  = 5'd0,
  parameter logic [7:0]  MDC_DIV   = 8'd40,
  parameter int          POLL_GAP  = 100000,
  parameter int          MAX_POLLS = 50
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic                cpu_valid,
  input  logic [ADDR_W-1:0]   cpu_address,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_wstrb,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                mac_valid,
  output logic [ADDR_W-1:0]   mac_address,
  output logic [DATA_W-1:0]   mac_wdata,
  output logic [DATA_W/8-1:0] mac_wstrb,
  input  logic [DATA_W-1:0]   mac_rdata,
  input  logic                mac_ready,
  output logic                init_done,
  output logic                link_up,
  output logic                init_err
);

  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS);

  init_state_e         state;
  logic                valid_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W/8-1:0] wstrb_r;
  logic [GAP_W-1:0]    gap_cnt;
  logic [POLL_W-1:0]   poll_cnt;
  logic [POLL_W-1:0]   poll_nxt;
  logic                restart_pend;
  logic                in_done;

  logic [7:0]          req_ofs;
  logic [DATA_W-1:0]   req_wdata;
  logic                req_wr;

  // Register access implied by each transaction state
  always_comb begin
    req_ofs   = MODER_OFS;
    req_wdata = '0;
    req_wr    = 1'b1;
    case (state)
      W_MRST: req_wdata = MODER_RST;
      W_MCLR: req_wdata = MODER_DEFAULT;
      W_MIIM: begin req_ofs = MIIMODER_OFS;   req_wdata = {24'b0, MDC_DIV}; end
      W_MA0:  begin req_ofs = MAC_ADDR0_OFS;  req_wdata = MAC_ADDR[31:0]; end
      W_MA1:  begin req_ofs = MAC_ADDR1_OFS;  req_wdata = {16'b0, MAC_ADDR[47:32]}; end
      W_MIIA: begin req_ofs = MIIADDRESS_OFS; req_wdata = {19'b0, PHY_BMSR, 3'b0, PHY_ADDR}; end
      W_MIIC: begin req_ofs = MIICOMMAND_OFS; req_wdata = MIICMD_RSTAT; end
      R_STAT: begin req_ofs = MIISTATUS_OFS;  req_wr = 1'b0; end
      R_RXD:  begin req_ofs = MIIRX_DATA_OFS; req_wr = 1'b0; end
      W_EN:   req_wdata = MODER_DEFAULT | MODER_TXEN | MODER_RXEN;
      default: ;
    endcase
  end

  assign poll_nxt = poll_cnt + POLL_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= W_MRST;
      valid_r      <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      wstrb_r      <= '0;
      gap_cnt      <= '0;
      poll_cnt     <= '0;
      restart_pend <= 1'b0;
      init_done    <= 1'b0;
      link_up      <= 1'b0;
      init_err     <= 1'b0;
    end else begin
      case (state)
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= W_MIIA;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        DONE: begin
          // A restart never cuts off a CPU access already presented
          if ((restart || restart_pend) && (!cpu_valid || mac_ready)) begin
            restart_pend <= 1'b0;
            init_done    <= 1'b0;
            link_up      <= 1'b0;
            init_err     <= 1'b0;
            poll_cnt     <= '0;
            state        <= W_MRST;
          end else if (restart) begin
            restart_pend <= 1'b1;
          end
        end
        default: begin
          if (!valid_r) begin
            valid_r <= 1'b1;
            addr_r  <= {{(ADDR_W-8){1'b0}}, req_ofs};
            wdata_r <= req_wdata;
            wstrb_r <= req_wr ? '1 : '0;
          end else if (mac_ready) begin
            valid_r <= 1'b0;
            case (state)
              W_MRST: state <= W_MCLR;
              W_MCLR: state <= W_MIIM;
              W_MIIM: state <= W_MA0;
              W_MA0:  state <= W_MA1;
              W_MA1:  state <= W_MIIA;
              W_MIIA: state <= W_MIIC;
              W_MIIC: state <= R_STAT;
              R_STAT: if (!mac_rdata[MIISTATUS_BUSY]) state <= R_RXD;
              R_RXD: begin
                if (mac_rdata[BMSR_LINK]) begin
                  link_up <= 1'b1;
                  state   <= W_EN;
                end else begin
                  poll_cnt <= poll_nxt;
                  if (poll_nxt == POLL_LAST) begin
                    init_err <= 1'b1;
                    state    <= W_EN;
                  end else begin
                    state <= GAP;
                  end
                end
              end
              W_EN: begin
                init_done <= 1'b1;
                state     <= DONE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign in_done     = (state == DONE);
  assign mac_valid   = in_done ? cpu_valid   : valid_r;
  assign mac_address = in_done ? cpu_address : addr_r;
  assign mac_wdata   = in_done ? cpu_wdata   : wdata_r;
  assign mac_wstrb   = in_done ? cpu_wstrb   : wstrb_r;
  assign cpu_rdata   = in_done ? mac_rdata   : '0;
  assign cpu_ready   = in_done & mac_ready;

endmodule

// File: tb/tb_iob_eth_init_ctrl.sv
// tb/tb_iob_eth_init_ctrl.sv - directed bench for iob_eth_init_ctrl with a behavioural MAC slave
module tb_iob_eth_init_ctrl;

  localparam int          ADDR_W    = 16;
  localparam int          DATA_W    = 32;
  localparam logic [47:0] MAC_ADDR  = 48'h0123_4567_89AB;
  localparam logic [4:0]  PHY_ADDR  = 5'd3;
  localparam logic [7:0]  MDC_DIV   = 8'd40;
  localparam int          POLL_GAP  = 10;
  localparam int          MAX_POLLS = 3;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } vec_t;

  typedef struct {
    vec_t v;
    int   cyc;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n, restart, cpu_valid;
  logic [15:0] cpu_address;
  logic [31:0] cpu_wdata, cpu_rdata, mac_wdata, mac_rdata;
  logic [3:0]  cpu_wstrb, mac_wstrb;
  logic        cpu_ready, mac_valid, mac_ready, init_done, link_up, init_err;
  logic [15:0] mac_address;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  xfer_t       log_q[$];
  logic [31:0] regs[0:63];
  int          busy_reads, link_fail_polls, rxd_cnt;

  iob_eth_init_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAC_ADDR(MAC_ADDR), .PHY_ADDR(PHY_ADDR),
    .MDC_DIV(MDC_DIV), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .cpu_valid(cpu_valid), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mac_valid(mac_valid), .mac_address(mac_address), .mac_wdata(mac_wdata),
    .mac_wstrb(mac_wstrb), .mac_rdata(mac_rdata), .mac_ready(mac_ready),
    .init_done(init_done), .link_up(link_up), .init_err(init_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // MAC slave: one-cycle ready per request, logs every transaction it accepts
  always @(posedge clk) begin
    xfer_t x;
    #1;
    if (mac_ready) begin
      mac_ready = 1'b0;
      mac_rdata = '0;
    end else if (mac_valid && rst_n) begin
      x.v   = {mac_address, mac_wdata, mac_wstrb};
      x.cyc = cyc;
      log_q.push_back(x);
      if (mac_wstrb != 4'h0) begin
        regs[mac_address[7:2]] = mac_wdata;
      end else if (mac_address == 16'h3C) begin
        mac_rdata = (busy_reads > 0) ? 32'h2 : 32'h0;
        if (busy_reads > 0) busy_reads--;
      end else if (mac_address == 16'h38) begin
        mac_rdata = (rxd_cnt < link_fail_polls) ? 32'h0 : 32'h4;
        rxd_cnt++;
      end else begin
        mac_rdata = regs[mac_address[7:2]];
      end
      mac_ready = 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int busy, input int lfail);
    rst_n = 1'b0;
    restart = 1'b0;
    cpu_valid = 1'b0;
    cpu_address = '0;
    cpu_wdata = '0;
    cpu_wstrb = '0;
    repeat (2) @(negedge clk);
    log_q.delete();
    busy_reads = busy;
    link_fail_polls = lfail;
    rxd_cnt = 0;
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, init_done, 1);
  endtask

  function automatic int count_addr(input logic [15:0] a, input bit wr);
    int c = 0;
    foreach (log_q[i])
      if (log_q[i].v.addr == a && ((log_q[i].v.wstrb != 4'h0) == wr)) c++;
    return c;
  endfunction

  initial begin
    vec_t exp_a[11];
    logic [31:0] rdata_cap;
    bit   ready_seen, done_at_ready;
    int   n, gaps, ready_cnt, last;

    exp_a[0]  = {16'h00, 32'h0000_0800, 4'hF};
    exp_a[1]  = {16'h00, 32'h0000_A000, 4'hF};
    exp_a[2]  = {16'h28, 32'h0000_0028, 4'hF};
    exp_a[3]  = {16'h40, 32'h4567_89AB, 4'hF};
    exp_a[4]  = {16'h44, 32'h0000_0123, 4'hF};
    exp_a[5]  = {16'h30, 32'h0000_0103, 4'hF};
    exp_a[6]  = {16'h2C, 32'h0000_0002, 4'hF};
    exp_a[7]  = {16'h3C, 32'h0000_0000, 4'h0};
    exp_a[8]  = {16'h38, 32'h0000_0000, 4'h0};
    exp_a[9]  = {16'h00, 32'h0000_A003, 4'hF};
    exp_a[10] = {16'h40, 32'h0000_0000, 4'h0};

    for (int i = 0; i < 64; i++) regs[i] = '0;
    mac_ready = 1'b0;
    mac_rdata = '0;
    rst_n = 1'b0;
    restart = 1'b0;
    cpu_valid = 1'b1;
    cpu_address = 16'h40;
    cpu_wdata = 32'hDEAD_BEEF;
    cpu_wstrb = 4'hF;
    busy_reads = 0;
    link_fail_polls = 0;
    rxd_cnt = 0;

    // Reset state, with a CPU request held to show it is not passed through
    repeat (2) @(negedge clk);
    check("rst mac_valid", mac_valid, 0);
    check("rst mac_bus", {mac_address, mac_wdata, mac_wstrb}, 0);
    check("rst status", {init_done, link_up, init_err}, 0);
    check("rst cpu side", {cpu_ready, cpu_rdata}, 0);

    // A: clean bring-up; CPU read of MAC_ADDR0 raised during init
    do_reset(0, 0);
    repeat (2) @(negedge clk);
    cpu_valid = 1'b1;
    cpu_address = 16'h40;
    cpu_wstrb = 4'h0;
    cpu_wdata = '0;
    ready_seen = 0;
    done_at_ready = 0;
    rdata_cap = '0;
    n = 0;
    while (!ready_seen && n < 500) begin
      @(negedge clk);
      n++;
      if (cpu_ready) begin
        ready_seen = 1;
        done_at_ready = init_done;
        rdata_cap = cpu_rdata;
      end
    end
    check("A cpu_ready seen", ready_seen, 1);
    check("A cpu stalled until done", done_at_ready, 1);
    check("A cpu rdata", rdata_cap, 32'h4567_89AB);
    @(posedge clk);
    #1 cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("A xfer count", log_q.size(), 11);
    for (int i = 0; i < 11; i++)
      check($sformatf("A xfer %0d", i), log_q[i].v, exp_a[i]);
    check("A status", {init_done, link_up, init_err}, 3'b110);

    // B: MIISTATUS busy for three reads
    do_reset(3, 0);
    wait_done("B done", 500);
    check("B xfer count", log_q.size(), 13);
    check("B status reads", count_addr(16'h3C, 0), 4);
    check("B rxd after busy", log_q[11].v.addr, 16'h38);
    check("B enable", log_q[12].v, {16'h00, 32'h0000_A003, 4'hF});

    // C: link down for two polls, then up
    do_reset(0, 2);
    wait_done("C done", 1000);
    check("C miiaddress writes", count_addr(16'h30, 1), 3);
    check("C miicommand writes", count_addr(16'h2C, 1), 3);
    check("C status", {link_up, init_err}, 2'b10);
    gaps = 0;
    for (int i = 0; i + 1 < log_q.size(); i++) begin
      if (log_q[i].v.addr == 16'h38 && log_q[i+1].v.addr == 16'h30) begin
        gaps++;
        check($sformatf("C poll gap %0d", gaps), (log_q[i+1].cyc - log_q[i].cyc) >= 11, 1);
      end
    end
    check("C gap count", gaps, 2);

    // D: link never comes up
    do_reset(0, 1000);
    wait_done("D done", 1000);
    check("D status", {init_done, link_up, init_err}, 3'b101);
    check("D rxd reads", count_addr(16'h38, 0), 3);
    last = log_q.size() - 1;
    check("D enable last", log_q[last].v, {16'h00, 32'h0000_A003, 4'hF});

    // E: restart during an in-flight CPU write
    @(negedge clk);
    log_q.delete();
    link_fail_polls = 0;
    rxd_cnt = 0;
    cpu_valid = 1'b1;
    cpu_address = 16'h04;
    cpu_wdata = 32'h55;
    cpu_wstrb = 4'hF;
    restart = 1'b1;
    ready_cnt = 0;
    n = 0;
    while (log_q.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
      restart = 1'b0;
      if (cpu_ready) begin
        ready_cnt++;
        @(posedge clk);
        #1 cpu_valid = 1'b0;
      end
    end
    restart = 1'b0;
    cpu_valid = 1'b0;
    check("E cpu_ready pulses", ready_cnt, 1);
    check("E cpu write first", log_q[0].v, {16'h04, 32'h0000_0055, 4'hF});
    check("E rerun starts", log_q[1].v, {16'h00, 32'h0000_0800, 4'hF});
    check("E flags cleared", {init_done, init_err}, 2'b00);
    wait_done("E done", 1000);
    check("E status", {link_up, init_err}, 2'b10);

    // F: asynchronous reset while the init transaction is outstanding
    do_reset(0, 0);
    n = 0;
    while (!mac_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("F valid before reset", mac_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("F async drop", {mac_valid, mac_address, mac_wstrb}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
